// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel debouncer with synchroniser, edge strobes and optional long-press detect
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            asynchronous active-low reset (0 = in reset)
//   bouncy_in      raw asynchronous inputs, one bit per channel
//   debounced_out  accepted stable level per channel
//   rise           1-cycle pulse when debounced_out[i] goes 0->1
//   fall           1-cycle pulse when debounced_out[i] goes 1->0
//   any_change     OR of all rise/fall strobes, same cycle as the strobes
//   long_press     1-cycle pulse when a channel has been held high HOLD_TICKS cycles
//
// Build option: DEBOUNCE_LONG_PRESS_EN enables the per-channel hold counters;
// without it long_press is tied to 0 and no hold counters exist.

module multi_debouncer #(
    parameter int N_CHANNELS   = 4,
    parameter int BOUNCE_TICKS = 100,
    parameter int HOLD_TICKS   = 6000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CHANNELS-1:0] bouncy_in,
    output logic [N_CHANNELS-1:0] debounced_out,
    output logic [N_CHANNELS-1:0] rise,
    output logic [N_CHANNELS-1:0] fall,
    output logic                  any_change,
    output logic [N_CHANNELS-1:0] long_press
);

    localparam int CW = $clog2(BOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BOUNCE_TICKS - 1);

    // Elaboration-time parameter sanity checks.
    if (N_CHANNELS < 1) begin : g_bad_n
        $error("multi_debouncer: N_CHANNELS must be >= 1");
    end
    if (BOUNCE_TICKS < 1) begin : g_bad_bounce
        $error("multi_debouncer: BOUNCE_TICKS must be >= 1");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("multi_debouncer: HOLD_TICKS must be >= 1");
    end

    logic [N_CHANNELS-1:0] sync1;
    logic [N_CHANNELS-1:0] sync2;
    logic [CW-1:0]         cnt_q [N_CHANNELS];
    logic [CW-1:0]         cnt_d [N_CHANNELS];
    logic [N_CHANNELS-1:0] level_d;
    logic [N_CHANNELS-1:0] rise_d;
    logic [N_CHANNELS-1:0] fall_d;

    // A sample that disagrees with the accepted level advances the counter;
    // any agreeing sample restarts it from 0, so only an unbroken run of
    // BOUNCE_TICKS disagreeing samples flips the output.
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            cnt_d[i]   = '0;
            level_d[i] = debounced_out[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            if (sync2[i] != debounced_out[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2[i];
                    rise_d[i]  = sync2[i];
                    fall_d[i]  = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1         <= '0;
            sync2         <= '0;
            debounced_out <= '0;
            rise          <= '0;
            fall          <= '0;
            any_change    <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1         <= bouncy_in;
            sync2         <= sync1;
            debounced_out <= level_d;
            rise          <= rise_d;
            fall          <= fall_d;
            any_change    <= |(rise_d | fall_d);
            for (int i = 0; i < N_CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic [HW-1:0]         hold_q [N_CHANNELS];
    logic [HW-1:0]         hold_d [N_CHANNELS];
    logic [N_CHANNELS-1:0] lp_d;

    // Hold counter saturates at HOLD_TICKS, so the pulse fires exactly once
    // per press; it is cleared whenever the accepted level is low.
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            hold_d[i] = '0;
            lp_d[i]   = 1'b0;
            if (debounced_out[i]) begin
                if (hold_q[i] < HOLD_MAX) begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end else begin
                    hold_d[i] = hold_q[i];
                end
                lp_d[i] = (hold_q[i] == HOLD_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_press <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_press <= lp_d;
            for (int i = 0; i < N_CHANNELS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    assign long_press = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed self-checking bench for multi_debouncer

module tb_multi_debouncer;

    localparam int N  = 4;
    localparam int BT = 100;
    localparam int HT = 1000;

    logic         clk;
    logic         rst;
    logic [N-1:0] bouncy_in;
    logic [N-1:0] debounced_out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         any_change;
    logic [N-1:0] long_press;

    int total;
    int bad;
    int rise_cnt [N];
    int fall_cnt [N];
    int lp_cnt   [N];
    int any_cnt;

    multi_debouncer #(
        .N_CHANNELS  (N),
        .BOUNCE_TICKS(BT),
        .HOLD_TICKS  (HT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bouncy_in    (bouncy_in),
        .debounced_out(debounced_out),
        .rise         (rise),
        .fall         (fall),
        .any_change   (any_change),
        .long_press   (long_press)
    );

    initial clk = 1'b0;
    always #41 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            lp_cnt[i]   = 0;
        end
        any_cnt = 0;
    endtask

    // Advance n posedges, sampling outputs on each following negedge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                rise_cnt[i] += int'(rise[i]);
                fall_cnt[i] += int'(fall[i]);
                lp_cnt[i]   += int'(long_press[i]);
            end
            any_cnt += int'(any_change);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_deb"},  32'(debounced_out), 32'h0);
        chk({tag, "_rise"}, 32'(rise),          32'h0);
        chk({tag, "_fall"}, 32'(fall),          32'h0);
        chk({tag, "_any"},  32'(any_change),    32'h0);
        chk({tag, "_lp"},   32'(long_press),    32'h0);
    endtask

    initial begin
        int ntog;
        total     = 0;
        bad       = 0;
        clr();
        rst       = 1'b1;
        bouncy_in = '0;

        // 1. reset with random inputs
        #5 rst = 1'b0;
        @(negedge clk);
        bouncy_in = N'($urandom);
        run(1);
        chk_all_zero("rst_c1");
        bouncy_in = N'($urandom);
        run(1);
        chk_all_zero("rst_c2");
        bouncy_in = '0;
        rst = 1'b1;
        run(1);
        chk_all_zero("post_rst");
        run(5);

        // 2. clean step on ch0
        clr();
        bouncy_in[0] = 1'b1;
        run(101);
        chk("step_deb_101", 32'(debounced_out), 32'h0);
        chk("step_early_rise", 32'(rise_cnt[0]), 0);
        run(1);
        chk("step_deb_102", 32'(debounced_out), 32'h1);
        chk("step_rise", 32'(rise), 32'h1);
        chk("step_any", 32'(any_change), 32'h1);
        chk("step_fall", 32'(fall), 32'h0);
        run(1);
        chk("step_rise_off", 32'(rise), 32'h0);
        chk("step_any_off", 32'(any_change), 32'h0);
        chk("step_deb_hold", 32'(debounced_out), 32'h1);
        run(20);
        chk("step_any_cnt", 32'(any_cnt), 1);

        // release ch0 back to 0
        clr();
        bouncy_in[0] = 1'b0;
        run(110);
        chk("rel0_fall_cnt", 32'(fall_cnt[0]), 1);
        chk("rel0_deb", 32'(debounced_out), 32'h0);

        // 3. bouncing ch0 ending high
        clr();
        ntog = $urandom_range(10, 29);
        if ((ntog % 2) == 0) ntog++;
        for (int t = 0; t < ntog - 1; t++) begin
            bouncy_in[0] = ~bouncy_in[0];
            run($urandom_range(1, 99));
        end
        bouncy_in[0] = ~bouncy_in[0];
        chk("bnc_level", 32'(bouncy_in[0]), 32'h1);
        run(101);
        chk("bnc_no_early", 32'(rise_cnt[0]), 0);
        chk("bnc_deb_101", 32'(debounced_out[0]), 32'h0);
        run(1);
        chk("bnc_rise", 32'(rise[0]), 32'h1);
        chk("bnc_deb_102", 32'(debounced_out[0]), 32'h1);
        run(30);
        chk("bnc_rise_cnt", 32'(rise_cnt[0]), 1);
        chk("bnc_fall_cnt", 32'(fall_cnt[0]), 0);

        // 4. ch2 pulses of 99 and 100 cycles
        clr();
        bouncy_in[2] = 1'b1;
        run(99);
        bouncy_in[2] = 1'b0;
        run(150);
        chk("p99_rise", 32'(rise_cnt[2]), 0);
        chk("p99_fall", 32'(fall_cnt[2]), 0);
        chk("p99_deb", 32'(debounced_out[2]), 32'h0);
        bouncy_in[2] = 1'b1;
        run(100);
        bouncy_in[2] = 1'b0;
        run(1);
        chk("p100_deb_101", 32'(debounced_out[2]), 32'h0);
        run(1);
        chk("p100_rise", 32'(rise[2]), 32'h1);
        run(99);
        chk("p100_deb_201", 32'(debounced_out[2]), 32'h1);
        chk("p100_no_fall", 32'(fall_cnt[2]), 0);
        run(1);
        chk("p100_fall", 32'(fall[2]), 32'h1);
        chk("p100_deb_202", 32'(debounced_out[2]), 32'h0);
        run(10);
        chk("p100_counts", 32'(rise_cnt[2] + fall_cnt[2]), 2);

        // 5. simultaneous ch1 rise and ch3 fall
        bouncy_in[3] = 1'b1;
        run(110);
        clr();
        bouncy_in[1] = 1'b1;
        bouncy_in[3] = 1'b0;
        run(101);
        chk("sim_no_early", 32'(any_cnt), 0);
        run(1);
        chk("sim_rise", 32'(rise), 32'h2);
        chk("sim_fall", 32'(fall), 32'h8);
        chk("sim_any", 32'(any_change), 32'h1);
        chk("sim_deb", 32'(debounced_out), 32'h3);
        run(1);
        chk("sim_any_off", 32'(any_change), 32'h0);
        run(10);
        chk("sim_any_cnt", 32'(any_cnt), 1);

        // 6. reset in mid-count on ch0
        bouncy_in[0] = 1'b0;
        run(110);
        clr();
        bouncy_in[0] = 1'b1;
        run(52);
        chk("mid_deb", 32'(debounced_out[0]), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_deb", 32'(debounced_out), 32'h0);
        run(2);
        chk_all_zero("mid_rst");
        rst = 1'b1;
        clr();
        run(101);
        chk("mid_deb_101", 32'(debounced_out[0]), 32'h0);
        chk("mid_no_early", 32'(rise_cnt[0]), 0);
        run(1);
        chk("mid_rise", 32'(rise[0]), 32'h1);
        chk("mid_deb_102", 32'(debounced_out[0]), 32'h1);
`ifdef DEBOUNCE_LONG_PRESS_EN
        run(999);
        chk("lp_early", 32'(lp_cnt[0]), 0);
        run(1);
        chk("lp_pulse", 32'(long_press[0]), 32'h1);
        run(1);
        chk("lp_off", 32'(long_press[0]), 32'h0);
        run(1500);
        chk("lp_once", 32'(lp_cnt[0]), 1);
        // release before threshold gives no pulse
        bouncy_in[0] = 1'b0;
        run(110);
        clr();
        bouncy_in[0] = 1'b1;
        run(102 + 500);
        bouncy_in[0] = 1'b0;
        run(1200);
        chk("lp_short", 32'(lp_cnt[0]), 0);
`else
        run(1200);
        chk("lp_tied", 32'(lp_cnt[0] + lp_cnt[1] + lp_cnt[2] + lp_cnt[3]), 0);
        chk("lp_now", 32'(long_press), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
